// File: rtl/sdram_init_cfg_pkg.sv
// rtl/sdram_init_cfg_pkg.sv - SDRAM init command encodings, mode-register fields and FSM states
package sdram_init_cfg_pkg;

  // SDRAM command bus {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LOAD_MODE    = 4'b0000,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_PRECHARGE    = 4'b0010,
    CMD_NOP          = 4'b0111
  } sdram_cmd_e;

  // Initialisation sequencer states
  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_PRE  = 3'd1,
    S_TRP  = 3'd2,
    S_AREF = 3'd3,
    S_TRFC = 3'd4,
    S_MRS  = 3'd5,
    S_TMRD = 3'd6,
    S_DONE = 3'd7
  } init_state_e;

  // Address bit that selects "all banks" on PRECHARGE
  localparam int A10_BIT = 10;

  // Mode-register word occupying A[9:0]
  function automatic logic [9:0] mode_word(input logic       wb_mode,
                                           input logic [2:0] cas_lat,
                                           input logic       burst_type,
                                           input logic [2:0] burst_len);
    return {wb_mode, 2'b00, cas_lat, burst_type, burst_len};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// rtl/sdram_init_timer.sv - loadable saturating down-counter with zero flag
module sdram_init_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins; otherwise count down and hold at zero (no wrap)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdram_init_cfg.sv
// rtl/sdram_init_cfg.sv - parametrised SDRAM power-up initialisation sequencer with re-init
module sdram_init_cfg
  import sdram_init_cfg_pkg::*;
#(
  parameter int         ADDR_W      = 13,
  parameter int         BA_W        = 2,
  parameter int         T_POWER_CYC = 20000,
  parameter int         T_RP_CYC    = 2,
  parameter int         T_RFC_CYC   = 7,
  parameter int         T_MRD_CYC   = 3,
  parameter int         AREF_NUM    = 8,
  parameter logic [2:0] CAS_LAT     = 3'd3,
  parameter logic       BURST_TYPE  = 1'b0,
  parameter logic [2:0] BURST_LEN   = 3'b111,
  parameter logic       WB_MODE     = 1'b0
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_reinit,
  output logic [3:0]        o_init_cmd,
  output logic [BA_W-1:0]   o_init_ba,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_init_done
);

  localparam int MAX_T  = max_int(max_int(T_POWER_CYC, T_RP_CYC), max_int(T_RFC_CYC, T_MRD_CYC));
  localparam int CNT_W  = $clog2(MAX_T) + 1;
  localparam int AREF_W = $clog2(AREF_NUM + 1);

  // Timer reload values: command states last one cycle, so gap states run T-1 cycles
  // and the timer reaches zero on the last of them (hence T-2). A gap of 1 skips the gap state.
  localparam logic [CNT_W-1:0] LD_PWR = CNT_W'((T_POWER_CYC > 0) ? T_POWER_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'((T_RP_CYC  > 1) ? T_RP_CYC  - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'((T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'((T_MRD_CYC > 1) ? T_MRD_CYC - 2 : 0);

  if ((T_POWER_CYC < 1) || (T_RP_CYC < 1) || (T_RFC_CYC < 1) || (T_MRD_CYC < 1)) begin : g_bad_timing
    $error("sdram_init_cfg: all timing parameters must be >= 1");
  end
  if (AREF_NUM < 1) begin : g_bad_aref
    $error("sdram_init_cfg: AREF_NUM must be >= 1");
  end
  if (ADDR_W < 11) begin : g_bad_addr
    $error("sdram_init_cfg: ADDR_W must be >= 11");
  end

  init_state_e         r_state;
  init_state_e         w_next;
  logic                r_pwr_armed;
  logic [AREF_W-1:0]   r_aref_left;
  logic                w_tmr_load;
  logic [CNT_W-1:0]    w_tmr_val;
  logic                w_tmr_zero;
  logic [3:0]          w_cmd;
  logic [ADDR_W-1:0]   w_addr;

  sdram_init_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk      (i_sysclk),
    .i_rst      (i_sysrst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // State register; reset restarts from the power-up wait
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // The power-up wait loads its timer on the first cycle out of reset
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_pwr_armed <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_pwr_armed <= 1'b1;
    end
  end

  // Refreshes still to issue: reloaded when a sequence starts, decremented per AUTO REFRESH
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_aref_left <= '0;
    end else if (w_next == S_PRE) begin
      r_aref_left <= AREF_W'(AREF_NUM);
    end else if (r_state == S_AREF) begin
      r_aref_left <= r_aref_left - AREF_W'(1);
    end
  end

  // Next-state logic and timer reloads on state entry
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_WAIT: begin
        if (!r_pwr_armed) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_PWR;
        end else if (w_tmr_zero) begin
          w_next = S_PRE;
        end
      end
      S_PRE: begin
        if (T_RP_CYC == 1) begin
          w_next = S_AREF;
        end else begin
          w_next     = S_TRP;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_RP;
        end
      end
      S_TRP: begin
        if (w_tmr_zero) begin
          w_next = S_AREF;
        end
      end
      S_AREF: begin
        if (T_RFC_CYC == 1) begin
          w_next = (r_aref_left == AREF_W'(1)) ? S_MRS : S_AREF;
        end else begin
          w_next     = S_TRFC;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_RFC;
        end
      end
      S_TRFC: begin
        if (w_tmr_zero) begin
          w_next = (r_aref_left == '0) ? S_MRS : S_AREF;
        end
      end
      S_MRS: begin
        if (T_MRD_CYC == 1) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_TMRD;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_MRD;
        end
      end
      S_TMRD: begin
        if (w_tmr_zero) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_reinit) begin
          w_next = S_PRE;
        end
      end
      default: begin
        w_next = S_WAIT;
      end
    endcase
  end

  // Command and address for the state being entered; everything else is NOP with zero address
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    case (w_next)
      S_PRE: begin
        w_cmd           = CMD_PRECHARGE;
        w_addr[A10_BIT] = 1'b1;
      end
      S_AREF: begin
        w_cmd = CMD_AUTO_REFRESH;
      end
      S_MRS: begin
        w_cmd       = CMD_LOAD_MODE;
        w_addr[9:0] = mode_word(WB_MODE, CAS_LAT, BURST_TYPE, BURST_LEN);
      end
      default: begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
      end
    endcase
  end

  // Registered outputs so the command mux sees glitch-free values aligned to the edge
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      o_init_cmd  <= CMD_NOP;
      o_init_ba   <= '0;
      o_init_addr <= '0;
      o_init_done <= 1'b0;
    end else begin
      o_init_cmd  <= w_cmd;
      o_init_ba   <= '0;
      o_init_addr <= w_addr;
      o_init_done <= (w_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_sdram_init_cfg.sv
// tb/tb_sdram_init_cfg.sv - directed table-driven bench for sdram_init_cfg
module tb_sdram_init_cfg;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MRS  = 4'b0000;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reinit;
  logic [3:0]  cmd_a, cmd_b;
  logic [1:0]  ba_a, ba_b;
  logic [12:0] addr_a, addr_b;
  logic        done_a, done_b;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  vec_t tv[11];

  always #5 clk = ~clk;

  sdram_init_cfg #(
    .ADDR_W(13), .BA_W(2), .T_POWER_CYC(10), .T_RP_CYC(2), .T_RFC_CYC(7),
    .T_MRD_CYC(3), .AREF_NUM(2), .CAS_LAT(3'd3), .BURST_TYPE(1'b0),
    .BURST_LEN(3'b111), .WB_MODE(1'b0)
  ) u_dut_a (
    .i_sysclk(clk), .i_sysrst(rst), .i_reinit(reinit),
    .o_init_cmd(cmd_a), .o_init_ba(ba_a), .o_init_addr(addr_a), .o_init_done(done_a)
  );

  sdram_init_cfg #(
    .ADDR_W(13), .BA_W(2), .T_POWER_CYC(10), .T_RP_CYC(2), .T_RFC_CYC(7),
    .T_MRD_CYC(3), .AREF_NUM(8), .CAS_LAT(3'd2), .BURST_TYPE(1'b0),
    .BURST_LEN(3'b111), .WB_MODE(1'b0)
  ) u_dut_b (
    .i_sysclk(clk), .i_sysrst(rst), .i_reinit(reinit),
    .o_init_cmd(cmd_b), .o_init_ba(ba_b), .o_init_addr(addr_b), .o_init_done(done_b)
  );

  // Expected {cmd, ba, addr, done} at cycle c for a sequence whose PRECHARGE is at cycle p
  function automatic logic [19:0] exp_out(input int c, input int p, input int n,
                                          input logic [12:0] mrs, input logic pd);
    logic [3:0]  cm;
    logic [12:0] ad;
    logic        dn;
    int          d;
    cm = C_NOP;
    ad = 13'h0;
    dn = pd;
    if (c >= p) begin
      d  = c - p;
      dn = (d >= 2 + 7 * n + 3);
      if (d == 0) begin
        cm = C_PRE;
        ad = 13'h400;
      end else if (d >= 2 && d < 2 + 7 * n && ((d - 2) % 7) == 0) begin
        cm = C_AREF;
      end else if (d == 2 + 7 * n) begin
        cm = C_MRS;
        ad = mrs;
      end
    end
    return {cm, 2'b00, ad, dn};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got cmd=%b ba=%0d addr=%h done=%b want cmd=%b ba=%0d addr=%h done=%b",
               name, cyc, act[19:16], act[15:14], act[13:1], act[0],
               exp[19:16], exp[15:14], exp[13:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check_both(input string tag, input int pa, input int pb, input logic pda, input logic pdb);
    check({tag, "_a"}, {cmd_a, ba_a, addr_a, done_a}, exp_out(cyc, pa, 2, 13'h037, pda));
    check({tag, "_b"}, {cmd_b, ba_b, addr_b, done_b}, exp_out(cyc, pb, 8, 13'h027, pdb));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, {cmd_a, ba_a, addr_a, done_a}, {C_NOP, 2'b00, 13'h0, 1'b0});
    check({tag, "_b"}, {cmd_b, ba_b, addr_b, done_b}, {C_NOP, 2'b00, 13'h0, 1'b0});
  endtask

  initial begin
    tv[0]  = '{9,  C_NOP,  13'h000, 1'b0};
    tv[1]  = '{10, C_PRE,  13'h400, 1'b0};
    tv[2]  = '{11, C_NOP,  13'h000, 1'b0};
    tv[3]  = '{12, C_AREF, 13'h000, 1'b0};
    tv[4]  = '{13, C_NOP,  13'h000, 1'b0};
    tv[5]  = '{19, C_AREF, 13'h000, 1'b0};
    tv[6]  = '{26, C_MRS,  13'h037, 1'b0};
    tv[7]  = '{27, C_NOP,  13'h000, 1'b0};
    tv[8]  = '{28, C_NOP,  13'h000, 1'b0};
    tv[9]  = '{29, C_NOP,  13'h000, 1'b1};
    tv[10] = '{39, C_NOP,  13'h000, 1'b1};

    rst    = 1'b1;
    reinit = 1'b0;
    repeat (3) tick();
    check_reset("reset");

    // T1 nominal + T6 (AREF_NUM=8, CAS 2) on the second instance
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i <= 81; i++) begin
      tick();
      check_both("t1", 10, 10, 1'b0, 1'b0);
      for (int k = 0; k < 11; k++) begin
        if (tv[k].cyc == cyc) begin
          check("t1_table", {cmd_a, ba_a, addr_a, done_a}, {tv[k].cmd, 2'b00, tv[k].addr, tv[k].done});
        end
      end
    end

    // T3 re-init pulse after cycle 81: PRECHARGE and done=0 at cycle 82
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    check_both("t3", 82, 82, 1'b1, 1'b1);
    for (int i = 0; i < 75; i++) begin
      tick();
      check_both("t3", 82, 82, 1'b1, 1'b1);
    end

    // T2 hold: idle cycles keep done high and bus at NOP
    for (int i = 0; i < 100; i++) begin
      tick();
      check_both("t2", 82, 82, 1'b1, 1'b1);
    end

    // T4 reinit pulses outside S_DONE are ignored
    rst = 1'b1;
    tick();
    check_reset("t4_reset");
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i <= 40; i++) begin
      reinit = (cyc == 5) || (cyc == 15) || (cyc == 27);
      tick();
      check_both("t4", 10, 10, 1'b0, 1'b0);
    end
    reinit = 1'b0;

    // T5 reset mid-sequence at cycle 20 for two cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i <= 20; i++) begin
      tick();
      check_both("t5_pre", 10, 10, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    check_reset("t5_rst1");
    tick();
    check_reset("t5_rst2");
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i <= 35; i++) begin
      tick();
      check_both("t5", 10, 10, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
